// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the 5- and 10-unit chute sensors,
// flags jams, arbitrates detections and hands accepted coins out one at a time from a FIFO.
module coin_acceptor #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int MIN_GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  input  logic       coin_ready,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       fifo_full
);

  localparam int CMAX = (TIMEOUT_CYC > DEBOUNCE_CYC) ? TIMEOUT_CYC : DEBOUNCE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW   = AW + 1;
  localparam int GW   = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_DEB, ST_HELD} ch_state_e;

  // Bit 0 is the 5-unit chute, bit 1 the 10-unit chute throughout.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] det;
  logic [1:0] jam_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sense_10, sense_5};
      sync2_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          synced;
    logic          det_c;
    logic          jam_c;

    assign synced     = sync2_q[c];
    assign det[c]     = det_c;
    assign jam_hit[c] = jam_c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_ARM;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // ARM needs three consecutive low samples: the synchroniser reads 0 for two
    // cycles after reset even when the chute is still blocked.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      det_c   = 1'b0;
      jam_c   = 1'b0;
      case (state_q)
        ST_ARM: begin
          if (synced) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(2)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_IDLE: begin
          if (synced) begin
            state_d = ST_DEB;
            cnt_d   = CW'(1);
          end
        end
        ST_DEB: begin
          if (!synced) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            det_c   = 1'b1;
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (!synced) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            jam_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      endcase
    end
  end

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q;
  logic [1:0]    coin_q;
  logic          reject_q, jam_q, fifo_full_q;
  logic          pop, push, reject_d, full_now;
  logic [1:0]    push_code;

  assign full_now  = (count_q == NW'(FIFO_DEPTH));
  assign push_code = det[1] ? 2'b10 : 2'b01;

  // A pop in the same cycle frees a slot, so a detection on a full queue is
  // only rejected when nothing leaves that cycle.
  always_comb begin
    pop      = (count_q != '0) && coin_ready && (gap_q == '0);
    push     = 1'b0;
    reject_d = 1'b0;
    if (!jam_q) begin
      if (det == 2'b11) begin
        reject_d = 1'b1;
      end else if (det != 2'b00) begin
        if (!full_now || pop) push = 1'b1;
        else                  reject_d = 1'b1;
      end
    end
    count_d = count_q + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      coin_q      <= 2'b00;
      reject_q    <= 1'b0;
      jam_q       <= 1'b0;
      fifo_full_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        coin_q   <= mem_q[rd_ptr_q];
        gap_q    <= GW'(MIN_GAP);
      end else begin
        coin_q <= 2'b00;
        if (gap_q != '0) gap_q <= gap_q - GW'(1);
      end
      count_q     <= count_d;
      reject_q    <= reject_d;
      jam_q       <= jam_q | (|jam_hit);
      fifo_full_q <= (count_d == NW'(FIFO_DEPTH));
    end
  end

  assign coin      = coin_q;
  assign reject    = reject_q;
  assign jam       = jam_q;
  assign fifo_full = fifo_full_q;

endmodule
